// File: rtl/ac_zone_scheduler_if.sv
// Plant/zone bundle for the AC zone scheduler.
// master drives zone sensors; slave is the scheduler.
interface ac_zone_scheduler_if;
  logic [19:0] zone_temp;
  logic [3:0]  zone_en;
  logic        heating;
  logic        cooling;
  logic [3:0]  valve;
  logic [1:0]  zone_sel;
  logic        busy;

  modport master (
    output zone_temp, zone_en,
    input  heating, cooling, valve, zone_sel, busy
  );

  modport slave (
    input  zone_temp, zone_en,
    output heating, cooling, valve, zone_sel, busy
  );
endinterface

// File: rtl/ac_zone_scheduler.sv
// Round-robin shared-plant HVAC scheduler: one zone served at a time,
// bounded dwell per grant and a forced plant-off lockout between grants.
module ac_zone_scheduler #(
  parameter int unsigned DWELL   = 16,
  parameter int unsigned LOCKOUT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  ac_zone_scheduler_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAT = 2'd1,
    COOL = 2'd2,
    LOCK = 2'd3
  } state_e;

  localparam logic [7:0] DWELL_M1 = 8'(DWELL - 1);
  localparam logic [7:0] LOCK_M1  = 8'(LOCKOUT - 1);

  state_e      state_q, state_d;
  logic        heat_q, heat_d;
  logic        cool_q, cool_d;
  logic [3:0]  valve_q, valve_d;
  logic [1:0]  sel_q, sel_d;
  logic [1:0]  last_q, last_d;
  logic [7:0]  dwell_q, dwell_d;
  logic [7:0]  lock_q, lock_d;
  logic        busy_q, busy_d;

  logic [4:0]  temp [4];
  logic [3:0]  heat_req, cool_req, req;
  logic        gnt_vld;
  logic [1:0]  gnt_idx;
  logic        svc_end;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      temp[i]     = bus.zone_temp[5*i +: 5];
      heat_req[i] = bus.zone_en[i] && (temp[i] <= 5'd18);
      cool_req[i] = bus.zone_en[i] && (temp[i] >= 5'd22);
    end
    req = heat_req | cool_req;
  end

  // first requester after the last served zone wins
  always_comb begin
    logic [1:0] idx;
    gnt_vld = 1'b0;
    gnt_idx = last_q;
    idx     = last_q;
    for (int k = 0; k < 4; k++) begin
      idx = last_q + 2'(k + 1);
      if (!gnt_vld && req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  always_comb begin
    svc_end = !bus.zone_en[sel_q] || (dwell_q == 8'd0);
    if (state_q == HEAT)
      svc_end = svc_end || (temp[sel_q] >= 5'd20);
    else
      svc_end = svc_end || (temp[sel_q] <= 5'd20);
  end

  always_comb begin
    state_d = state_q;
    heat_d  = heat_q;
    cool_d  = cool_q;
    valve_d = valve_q;
    sel_d   = sel_q;
    last_d  = last_q;
    dwell_d = dwell_q;
    lock_d  = lock_q;
    unique case (state_q)
      IDLE: begin
        heat_d  = 1'b0;
        cool_d  = 1'b0;
        valve_d = 4'b0;
        if (gnt_vld) begin
          state_d = heat_req[gnt_idx] ? HEAT : COOL;
          heat_d  = heat_req[gnt_idx];
          cool_d  = !heat_req[gnt_idx];
          valve_d = 4'(4'b0001 << gnt_idx);
          sel_d   = gnt_idx;
          dwell_d = DWELL_M1;
        end
      end
      HEAT, COOL: begin
        if (svc_end) begin
          state_d = LOCK;
          heat_d  = 1'b0;
          cool_d  = 1'b0;
          valve_d = 4'b0;
          last_d  = sel_q;
          lock_d  = LOCK_M1;
        end else if (dwell_q != 8'd0) begin
          dwell_d = dwell_q - 8'd1;
        end
      end
      LOCK: begin
        heat_d  = 1'b0;
        cool_d  = 1'b0;
        valve_d = 4'b0;
        if (lock_q == 8'd0)
          state_d = IDLE;
        else
          lock_d = lock_q - 8'd1;
      end
      default: begin
        state_d = IDLE;
        heat_d  = 1'b0;
        cool_d  = 1'b0;
        valve_d = 4'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      heat_q  <= 1'b0;
      cool_q  <= 1'b0;
      valve_q <= 4'b0;
      sel_q   <= 2'd0;
      last_q  <= 2'd3;
      dwell_q <= 8'd0;
      lock_q  <= 8'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      heat_q  <= heat_d;
      cool_q  <= cool_d;
      valve_q <= valve_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      dwell_q <= dwell_d;
      lock_q  <= lock_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.heating  = heat_q;
  assign bus.cooling  = cool_q;
  assign bus.valve    = valve_q;
  assign bus.zone_sel = sel_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_ac_zone_scheduler.sv
// Bench for ac_zone_scheduler: directed scenarios feed a service-period
// scoreboard; a negedge monitor reassembles periods and checks them.
module tb_ac_zone_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ac_zone_scheduler_if bus ();

  ac_zone_scheduler #(.DWELL(16), .LOCKOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int zone;
    int cool;
    int len;
    int gap;
  } per_t;

  per_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int z, input int c, input int l, input int g);
    per_t p;
    p.zone = z;
    p.cool = c;
    p.len  = l;
    p.gap  = g;
    exp_q.push_back(p);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic temps(input logic [4:0] t0, input logic [4:0] t1,
                       input logic [4:0] t2, input logic [4:0] t3);
    bus.zone_temp = {t3, t2, t1, t0};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  // monitor: rebuild each service period from the valve outputs
  int cur_len  = 0;
  int cur_zone = 0;
  int cur_cool = 0;
  int cur_gap  = 0;
  int gap      = 0;

  always @(negedge clk) begin
    int z;
    per_t e;
    chk("no_overlap", int'(bus.heating && bus.cooling), 0);
    chk("cmd_vs_valve", int'(bus.heating || bus.cooling),
        int'(bus.valve != 4'b0));
    if (bus.valve != 4'b0) begin
      z = 0;
      for (int i = 0; i < 4; i++)
        if (bus.valve[i]) z = i;
      chk("valve_onehot", $countones(bus.valve), 1);
      chk("sel_vs_valve", int'(bus.zone_sel), z);
      if (cur_len == 0) begin
        cur_zone = z;
        cur_cool = int'(bus.cooling);
        cur_gap  = gap;
      end else begin
        chk("mode_stable", int'(bus.cooling), cur_cool);
      end
      cur_len++;
    end else begin
      if (cur_len > 0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_period: zone %0d len %0d, none expected",
                   cur_zone, cur_len);
        end else begin
          e = exp_q.pop_front();
          chk("period_zone", cur_zone, e.zone);
          chk("period_mode", cur_cool, e.cool);
          chk("period_len", cur_len, e.len);
          if (e.gap >= 0) chk("period_gap", cur_gap, e.gap);
        end
        cur_len = 0;
        gap = 1;
      end else begin
        gap++;
      end
    end
  end

  initial begin
    int wait_n;
    bus.zone_en = 4'b0;
    temps(20, 20, 20, 20);

    // reset state
    tick(2);
    chk("rst_heating", int'(bus.heating), 0);
    chk("rst_cooling", int'(bus.cooling), 0);
    chk("rst_valve", int'(bus.valve), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_zone_sel", int'(bus.zone_sel), 0);
    rst = 1'b0;

    // heat zone0, satisfied after 4 cycles, 4-cycle lock
    push(0, 0, 4, -1);
    bus.zone_en = 4'b0001;
    temps(15, 20, 20, 20);
    tick(1);
    chk("heat_latency", int'(bus.heating), 1);
    chk("heat_valve", int'(bus.valve), 1);
    chk("heat_busy", int'(bus.busy), 1);
    tick(3);
    temps(20, 20, 20, 20);
    tick(1);
    chk("sat_heat_off", int'(bus.heating), 0);
    chk("lock_busy_first", int'(bus.busy), 1);
    tick(3);
    chk("lock_busy_last", int'(bus.busy), 1);
    tick(1);
    chk("lock_to_idle", int'(bus.busy), 0);
    tick(3);

    // continuous cool demand: dwell limit then lockout
    push(0, 1, 16, -1);
    push(0, 1, 16, 5);
    temps(25, 20, 20, 20);
    tick(40);
    temps(20, 20, 20, 20);
    tick(10);

    // all zones heating: round-robin 0,1,2,3,0
    do_reset();
    bus.zone_en = 4'b1111;
    temps(10, 10, 10, 10);
    push(0, 0, 16, -1);
    push(1, 0, 16, 5);
    push(2, 0, 16, 5);
    push(3, 0, 16, 5);
    push(0, 0, 16, 5);
    tick(102);
    temps(20, 20, 20, 20);
    tick(10);

    // heat zone0 vs cool zone1: mode has no priority
    do_reset();
    bus.zone_en = 4'b0011;
    temps(10, 30, 20, 20);
    push(0, 0, 16, -1);
    push(1, 1, 16, 5);
    tick(40);
    temps(20, 20, 20, 20);
    tick(10);

    // dead band everywhere: plant stays idle
    bus.zone_en = 4'b1111;
    temps(19, 20, 21, 21);
    for (int i = 0; i < 100; i++) begin
      tick(1);
      chk("deadband_idle",
          int'(bus.busy | bus.heating | bus.cooling | (|bus.valve)), 0);
    end

    // disable zone2 mid-heat
    do_reset();
    bus.zone_en = 4'b0100;
    temps(20, 20, 10, 20);
    push(2, 0, 3, -1);
    tick(1);
    chk("z2_valve", int'(bus.valve), 4);
    tick(2);
    bus.zone_en = 4'b0000;
    tick(1);
    chk("dis_lock_busy", int'(bus.busy), 1);
    chk("dis_valve_off", int'(bus.valve), 0);
    tick(10);
    chk("sel_held", int'(bus.zone_sel), 2);
    chk("dis_idle", int'(bus.busy), 0);

    // reset mid-cool, then zone0 wins first
    bus.zone_en = 4'b0011;
    temps(20, 25, 20, 20);
    push(1, 1, 3, -1);
    tick(1);
    chk("z1_cool", int'(bus.cooling), 1);
    tick(2);
    rst = 1'b1;
    temps(10, 25, 20, 20);
    tick(1);
    chk("midrst_cooling", int'(bus.cooling), 0);
    chk("midrst_heating", int'(bus.heating), 0);
    chk("midrst_valve", int'(bus.valve), 0);
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_sel", int'(bus.zone_sel), 0);
    rst = 1'b0;
    push(0, 0, 3, 1);
    tick(1);
    chk("post_rst_heat", int'(bus.heating), 1);
    chk("post_rst_valve", int'(bus.valve), 1);
    tick(2);
    bus.zone_en = 4'b0000;
    temps(20, 20, 20, 20);
    tick(10);

    wait_n = 0;
    while (exp_q.size() > 0 && wait_n < 50) begin
      tick(1);
      wait_n++;
    end
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
